// File: rtl/rsa_sequencer_if.sv
// rsa_sequencer_if: keygen, requester and exponentiation-unit signals of the RSA sequencer
interface rsa_sequencer_if;
  logic [7:0] p_in, q_in, p_out, q_out, ekg_key, e_key;
  logic [15:0] dkg_key, dkg_n, d_key, n_out, enc_msg, dec_msg;
  logic [15:0] mm_base, mm_exp, mm_mod, mm_result, result;
  logic keygen_req, ekg_start, ekg_finish, dkg_start, dkg_finish, keys_valid;
  logic enc_req, enc_ack, dec_req, dec_ack, mm_start, mm_finished;
  logic result_valid, result_tag, busy, error;
  modport master (
    input p_in, q_in, keygen_req, ekg_finish, ekg_key, dkg_finish, dkg_key, dkg_n,
          enc_req, enc_msg, dec_req, dec_msg, mm_finished, mm_result,
    output ekg_start, dkg_start, p_out, q_out, e_key, d_key, n_out, keys_valid,
           enc_ack, dec_ack, mm_start, mm_base, mm_exp, mm_mod,
           result, result_valid, result_tag, busy, error
  );
  modport slave (
    output p_in, q_in, keygen_req, ekg_finish, ekg_key, dkg_finish, dkg_key, dkg_n,
           enc_req, enc_msg, dec_req, dec_msg, mm_finished, mm_result,
    input ekg_start, dkg_start, p_out, q_out, e_key, d_key, n_out, keys_valid,
          enc_ack, dec_ack, mm_start, mm_base, mm_exp, mm_mod,
          result, result_valid, result_tag, busy, error
  );
endinterface

// File: rtl/rsa_sequencer.sv
// rsa_sequencer: orders key generation and round-robin shares the exponentiation unit
module rsa_sequencer #(
  parameter int unsigned MAX_WAIT = 65535
) (
  input logic clk,
  input logic rst,
  rsa_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, EKG_START, EKG_WAIT, DKG_START, DKG_WAIT, READY, MM_START, MM_WAIT} state_t;
  state_t state, state_nx;
  logic [15:0] cnt, d_r, n_r, base_r, exp_r, mod_r, res_r;
  logic [7:0] p_r, q_r, e_r;
  logic seen_low, last_grant, kv, err, rv, tag;
  logic fin, waiting, done, tmo, kg_acc, req_acc, pick_dec;
  assign waiting = state == EKG_WAIT || state == DKG_WAIT || state == MM_WAIT;
  assign fin = state == EKG_WAIT ? bus.ekg_finish : state == DKG_WAIT ? bus.dkg_finish : bus.mm_finished;
  // a finish only counts once it has been sampled low inside the current wait
  assign done = waiting && seen_low && fin;
  assign tmo = waiting && !done && cnt == 16'(MAX_WAIT - 1);
  assign kg_acc = (state == IDLE || state == READY) && bus.keygen_req;
  assign req_acc = state == READY && !bus.keygen_req && kv && (bus.enc_req || bus.dec_req);
  assign pick_dec = bus.dec_req && (!bus.enc_req || !last_grant);
  always_comb begin
    state_nx = state;
    if (kg_acc) state_nx = EKG_START;
    else if (req_acc) state_nx = MM_START;
    else if (tmo) state_nx = IDLE;
    else case (state)
      EKG_START: state_nx = EKG_WAIT;
      EKG_WAIT:  state_nx = done ? DKG_START : EKG_WAIT;
      DKG_START: state_nx = DKG_WAIT;
      DKG_WAIT:  state_nx = done ? READY : DKG_WAIT;
      MM_START:  state_nx = MM_WAIT;
      MM_WAIT:   state_nx = done ? READY : MM_WAIT;
      default:   state_nx = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      seen_low <= 1'b0;
      last_grant <= 1'b1;
      {p_r, q_r, e_r} <= '0;
      {d_r, n_r, base_r, exp_r, mod_r, res_r} <= '0;
      {kv, err, rv, tag} <= '0;
    end else begin
      state <= state_nx;
      cnt <= waiting && state_nx == state ? cnt + 16'd1 : '0;
      seen_low <= waiting && state_nx == state && (seen_low || !fin);
      rv <= done && state == MM_WAIT;
      if (kg_acc) begin
        p_r <= bus.p_in;
        q_r <= bus.q_in;
        kv <= 1'b0;
        err <= 1'b0;
      end
      if (req_acc) begin
        last_grant <= pick_dec;
        base_r <= pick_dec ? bus.dec_msg : bus.enc_msg;
        exp_r <= pick_dec ? d_r : {8'h00, e_r};
        mod_r <= n_r;
      end
      if (done && state == EKG_WAIT) e_r <= bus.ekg_key;
      if (done && state == DKG_WAIT) begin
        d_r <= bus.dkg_key;
        n_r <= bus.dkg_n;
        kv <= 1'b1;
      end
      if (done && state == MM_WAIT) begin
        res_r <= bus.mm_result;
        tag <= last_grant;
      end
      if (tmo) begin
        err <= 1'b1;
        kv <= 1'b0;
      end
    end
  end
  assign bus.ekg_start = state == EKG_START;
  assign bus.dkg_start = state == DKG_START;
  assign bus.mm_start = state == MM_START;
  assign bus.enc_ack = state == MM_START && !last_grant;
  assign bus.dec_ack = state == MM_START && last_grant;
  assign bus.busy = !(state == IDLE || state == READY);
  assign bus.p_out = p_r;
  assign bus.q_out = q_r;
  assign bus.e_key = e_r;
  assign bus.d_key = d_r;
  assign bus.n_out = n_r;
  assign bus.keys_valid = kv;
  assign bus.error = err;
  assign bus.mm_base = base_r;
  assign bus.mm_exp = exp_r;
  assign bus.mm_mod = mod_r;
  assign bus.result = res_r;
  assign bus.result_valid = rv;
  assign bus.result_tag = tag;
endmodule

// File: tb/tb_rsa_sequencer.sv
// tb_rsa_sequencer: directed bench with a cycle model of the sequencer rules plus literal checks
module tb_rsa_sequencer;
  logic clk = 0;
  logic rst = 1;
  int errors = 0;
  int checks = 0;
  rsa_sequencer_if bus();
  rsa_sequencer #(.MAX_WAIT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam int MW = 8;
  int ph, waited;
  bit live = 0, low_seen, m_fin, m_g;
  logic [7:0] m_p, m_q, m_e;
  logic [15:0] m_d, m_n, m_base, m_exp, m_mod, m_res;
  bit m_kv, m_err, m_rv, m_tag, m_last;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  function automatic logic sig(input int w);
    return w == 0 ? bus.ekg_start : w == 1 ? bus.dkg_start : w == 2 ? bus.keys_valid :
           w == 3 ? bus.enc_ack : w == 4 ? bus.dec_ack : bus.result_valid;
  endfunction
  task automatic await_sig(input int w, input string nm);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sig(w) === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: not seen within 20 cycles", nm);
  endtask
  // phases: 0 idle, 1 ekg start, 2 ekg wait, 3 dkg start, 4 dkg wait, 5 ready, 6 mm start, 7 mm wait
  always @(posedge clk) begin
    if (rst) begin
      live = 1; ph = 0; waited = 0; low_seen = 0; m_last = 1;
      m_p = 0; m_q = 0; m_e = 0; m_d = 0; m_n = 0; m_base = 0; m_exp = 0; m_mod = 0; m_res = 0;
      m_kv = 0; m_err = 0; m_rv = 0; m_tag = 0;
    end else begin
      m_rv = 0;
      m_fin = ph == 2 ? bus.ekg_finish : ph == 4 ? bus.dkg_finish : bus.mm_finished;
      if ((ph == 0 || ph == 5) && bus.keygen_req) begin
        m_p = bus.p_in; m_q = bus.q_in; m_kv = 0; m_err = 0; ph = 1;
      end else if (ph == 5 && m_kv && (bus.enc_req || bus.dec_req)) begin
        m_g = (bus.enc_req && bus.dec_req) ? !m_last : bus.dec_req;
        m_last = m_g;
        m_base = m_g ? bus.dec_msg : bus.enc_msg;
        m_exp = m_g ? m_d : 16'(m_e);
        m_mod = m_n;
        ph = 6;
      end else if (ph == 1 || ph == 3 || ph == 6) begin
        ph = ph + 1; waited = 0; low_seen = 0;
      end else if (ph == 2 || ph == 4 || ph == 7) begin
        if (low_seen && m_fin) begin
          if (ph == 2) begin m_e = bus.ekg_key; ph = 3; end
          else if (ph == 4) begin m_d = bus.dkg_key; m_n = bus.dkg_n; m_kv = 1; ph = 5; end
          else begin m_res = bus.mm_result; m_tag = m_last; m_rv = 1; ph = 5; end
        end else begin
          waited++;
          if (!m_fin) low_seen = 1;
          if (waited == MW) begin m_err = 1; m_kv = 0; ph = 0; end
        end
      end
    end
  end
  always @(negedge clk) if (live) begin
    chk("ekg_start", bus.ekg_start, ph == 1);
    chk("dkg_start", bus.dkg_start, ph == 3);
    chk("mm_start", bus.mm_start, ph == 6);
    chk("enc_ack", bus.enc_ack, ph == 6 && !m_last);
    chk("dec_ack", bus.dec_ack, ph == 6 && m_last);
    chk("busy", bus.busy, !(ph == 0 || ph == 5));
    chk("keys_valid", bus.keys_valid, m_kv);
    chk("error", bus.error, m_err);
    chk("result_valid", bus.result_valid, m_rv);
    chk("result", bus.result, m_res);
    chk("result_tag", bus.result_tag, m_tag);
    chk("p_out", bus.p_out, m_p);
    chk("q_out", bus.q_out, m_q);
    chk("e_key", bus.e_key, m_e);
    chk("d_key", bus.d_key, m_d);
    chk("n_out", bus.n_out, m_n);
    chk("mm_base", bus.mm_base, m_base);
    chk("mm_exp", bus.mm_exp, m_exp);
    chk("mm_mod", bus.mm_mod, m_mod);
  end
  task automatic do_keygen(input logic [7:0] p, q, e, input logic [15:0] d, n);
    bus.p_in = p; bus.q_in = q; bus.keygen_req = 1;
    tick();
    bus.keygen_req = 0;
    chk("kg ekg_start", bus.ekg_start, 1);
    chk("kg error cleared", bus.error, 0);
    tick();
    chk("ekg_start one cycle", bus.ekg_start, 0);
    tick();
    bus.ekg_key = e; bus.ekg_finish = 1;
    await_sig(1, "dkg_start");
    bus.ekg_finish = 0;
    tick();
    chk("dkg_start one cycle", bus.dkg_start, 0);
    tick();
    bus.dkg_key = d; bus.dkg_n = n; bus.dkg_finish = 1;
    await_sig(2, "keys_valid");
    bus.dkg_finish = 0;
    chk("kg e_key", bus.e_key, e);
    chk("kg d_key", bus.d_key, d);
    chk("kg n_out", bus.n_out, n);
    chk("kg p_out", bus.p_out, p);
    chk("kg q_out", bus.q_out, q);
  endtask
  task automatic mm_run(input logic [15:0] res);
    repeat (3) tick();
    bus.mm_result = res; bus.mm_finished = 1;
    await_sig(5, "result_valid");
    bus.mm_finished = 0;
  endtask
  initial begin
    bus.p_in = 0; bus.q_in = 0; bus.keygen_req = 0; bus.ekg_finish = 0; bus.ekg_key = 0;
    bus.dkg_finish = 0; bus.dkg_key = 0; bus.dkg_n = 0; bus.enc_req = 0; bus.enc_msg = 0;
    bus.dec_req = 0; bus.dec_msg = 0; bus.mm_finished = 0; bus.mm_result = 0;
    repeat (3) tick();
    chk("rst keys_valid", bus.keys_valid, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst error", bus.error, 0);
    chk("rst result", bus.result, 0);
    rst = 0;
    bus.enc_req = 1;
    repeat (2) tick();
    chk("no grant without keys", bus.enc_ack, 0);
    bus.enc_req = 0;
    do_keygen(61, 53, 17, 2753, 3233);
    bus.enc_msg = 65; bus.dec_msg = 2790; bus.enc_req = 1; bus.dec_req = 1;
    await_sig(3, "tie enc_ack");
    chk("tie dec_ack low", bus.dec_ack, 0);
    chk("tie mm_start", bus.mm_start, 1);
    chk("enc mm_base", bus.mm_base, 65);
    chk("enc mm_exp", bus.mm_exp, 17);
    chk("enc mm_mod", bus.mm_mod, 3233);
    bus.enc_req = 0;
    mm_run(2790);
    chk("enc result", bus.result, 2790);
    chk("enc tag", bus.result_tag, 0);
    tick();
    chk("dec_ack at F+2", bus.dec_ack, 1);
    chk("dec mm_start at F+2", bus.mm_start, 1);
    chk("dec mm_exp", bus.mm_exp, 2753);
    chk("dec mm_base", bus.mm_base, 2790);
    bus.dec_req = 0;
    mm_run(65);
    chk("dec result", bus.result, 65);
    chk("dec tag", bus.result_tag, 1);
    bus.mm_finished = 1; bus.enc_msg = 100; bus.enc_req = 1;
    await_sig(3, "stale enc_ack");
    bus.enc_req = 0;
    repeat (2) begin
      tick();
      chk("stale no capture", bus.result_valid, 0);
    end
    bus.mm_finished = 0;
    tick();
    chk("stale low no capture", bus.result_valid, 0);
    bus.mm_result = 1234; bus.mm_finished = 1;
    await_sig(5, "stale result_valid");
    bus.mm_finished = 0;
    chk("stale result", bus.result, 1234);
    chk("stale tag", bus.result_tag, 0);
    bus.p_in = 11; bus.q_in = 13; bus.keygen_req = 1;
    tick();
    bus.keygen_req = 0;
    chk("to ekg_start", bus.ekg_start, 1);
    chk("to keys cleared", bus.keys_valid, 0);
    chk("to p_out", bus.p_out, 11);
    repeat (8) begin
      tick();
      chk("to busy while waiting", bus.busy, 1);
      chk("to error not yet", bus.error, 0);
    end
    tick();
    chk("to error", bus.error, 1);
    chk("to idle", bus.busy, 0);
    chk("to keys_valid", bus.keys_valid, 0);
    bus.enc_req = 1;
    do_keygen(61, 53, 17, 2753, 3233);
    tick();
    chk("pending enc_ack", bus.enc_ack, 1);
    bus.enc_req = 0;
    repeat (2) tick();
    bus.mm_finished = 1; rst = 1;
    tick();
    chk("rst mid keys_valid", bus.keys_valid, 0);
    chk("rst mid busy", bus.busy, 0);
    chk("rst mid result_valid", bus.result_valid, 0);
    chk("rst mid mm_start", bus.mm_start, 0);
    rst = 0; bus.mm_finished = 0;
    tick();
    chk("after rst result_valid", bus.result_valid, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/rsa_sequencer.md
# rsa_sequencer

Control block for the RSA datapath. It runs key generation in order: encryption-key generator first, then decryption-key generator. It then shares the single modular-exponentiation unit between an encrypt requester and a decrypt requester, using round-robin arbitration. It drives all start pulses, holds the generated keys and the exponentiation operands stable, and reports results with a source tag.

## Interface
- MAX_WAIT, 65535: cycles allowed in any wait state before a timeout; range 1..65535.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- p_in, q_in  in  8 each  prime operands, sampled on keygen accept.
- keygen_req  in  1  request (re)generation of keys.
- ekg_start  out  1  one-cycle start pulse to the encryption-key generator.
- ekg_finish  in  1  done flag from the encryption-key generator.
- ekg_key  in  8  encryption key from the generator.
- dkg_start  out  1  one-cycle start pulse to the decryption-key generator.
- dkg_finish  in  1  done flag from the decryption-key generator.
- dkg_key  in  16  decryption key from the generator.
- dkg_n  in  16  modulus from the generator.
- p_out, q_out  out  8 each  latched primes to both generators.
- e_key  out  8  latched encryption key.
- d_key  out  16  latched decryption key.
- n_out  out  16  latched modulus.
- keys_valid  out  1  the three latched keys above are valid.
- enc_req  in  1  encrypt request.
- enc_msg  in  16  message to encrypt.
- enc_ack  out  1  one-cycle acknowledge for an encrypt request.
- dec_req  in  1  decrypt request.
- dec_msg  in  16  message to decrypt.
- dec_ack  out  1  one-cycle acknowledge for a decrypt request.
- mm_start  out  1  one-cycle start pulse to the exponentiation unit.
- mm_base  out  16  base operand.
- mm_exp  out  16  exponent operand.
- mm_mod  out  16  modulus operand.
- mm_finished  in  1  done flag from the exponentiation unit.
- mm_result  in  16  result from the exponentiation unit.
- result  out  16  captured result.
- result_valid  out  1  one-cycle pulse when result updates.
- result_tag  out  1  source of result: 0 = encrypt, 1 = decrypt.
- busy  out  1  high in any state other than IDLE and READY.
- error  out  1  sticky timeout flag.

## Operation
- States: IDLE, EKG_START, EKG_WAIT, DKG_START, DKG_WAIT, READY, MM_START, MM_WAIT.
- IDLE or READY with keygen_req = 1:
  - latch p_in and q_in into p_out and q_out.
  - clear keys_valid and error.
  - go to EKG_START.
  - keygen_req has priority over enc_req and dec_req.
- EKG_START: ekg_start = 1 for this cycle only, then go to EKG_WAIT.
- EKG_WAIT:
  - Finish is edge-qualified: ekg_finish must be seen low at least once in EKG_WAIT, then seen high. A level left high from an earlier run is never accepted.
  - On qualified high: latch e_key from ekg_key, go to DKG_START.
- DKG_START and DKG_WAIT behave the same way, using dkg_start and dkg_finish.
  - On qualified high: latch d_key from dkg_key and n_out from dkg_n, set keys_valid = 1, go to READY.
- READY with keys_valid = 1 and at least one request high:
  - Arbitrate round-robin. The last_grant register resets to decrypt, so encrypt wins the first tie.
  - Latch mm_base from the granted message.
  - Set mm_exp = {8'h00, e_key} for encrypt, or d_key for decrypt. Set mm_mod = n_out.
  - Pulse the matching ack, go to MM_START.
- A request must be held high until its ack. Requests are ignored while keys_valid = 0 and while busy; they stay pending.
- MM_START: mm_start = 1 for one cycle, then go to MM_WAIT.
- MM_WAIT:
  - mm_finished is edge-qualified, the same as the generator finish flags.
  - On qualified high: result = mm_result, result_tag = granted source, result_valid pulses, go to READY.
- Operand hold: mm_base, mm_exp, mm_mod, p_out and q_out change only on acceptance events. They are stable through every wait state.
- Timeout:
  - A wait counter is cleared on entry to each wait state and increments every cycle in that state.
  - When the count reaches MAX_WAIT without a qualified finish: set error = 1, clear keys_valid, go to IDLE.
- keygen_req during busy is ignored. It is not queued.

## Timing
- Reset:
  - All outputs are 0; state is IDLE; last_grant = decrypt; wait counter = 0.
  - Reset asserted mid-operation: at the next edge, all start and ack pulses drop and keys_valid = 0.
- keygen_req accepted at edge T: ekg_start is high during cycle T+1 only.
- Qualified ekg_finish sampled at edge W: dkg_start is high during cycle W+1.
- Qualified dkg_finish sampled at edge X: keys_valid = 1 and state is READY from cycle X+1.
- Request sampled in READY at edge R:
  - ack and mm_start are both high in cycle R+1.
  - Operands are valid from cycle R+1.
- Qualified mm_finished sampled at edge F:
  - result and result_tag are valid and result_valid pulses in cycle F+1; the state is READY in F+1.
  - The next request can be sampled at edge F+1, giving mm_start in cycle F+2.
- Throughput: at most one exponentiation in flight.

## Test plan
- Key generation: reset, then keygen_req with p=61, q=53. Generator stubs return e=17, d=2753, n=3233. Required: one ekg_start pulse, then one dkg_start pulse. keys_valid rises with e_key=17, d_key=2753, n_out=3233.
- Encrypt: enc_req with enc_msg=65. Required: mm_exp=17, mm_mod=3233, one enc_ack. Stub returns 2790, giving result=2790 with result_tag=0.
- Tie and round-robin: enc_req and dec_req both held high (dec_msg=2790). Required: encrypt is granted first. Decrypt is granted next, with mm_exp=2753, and its result 65 has result_tag=1.
- Stale finish: mm_finished held high across the start pulse. Required: no capture until mm_finished goes low and then high again.
- Timeout: MAX_WAIT=8 and ekg_finish never rises. Required: error=1 and state IDLE after 8 wait cycles. A following keygen_req clears error.
- Reset mid-operation: rst asserted during MM_WAIT. Required: next cycle keys_valid=0, busy=0, and no result_valid pulse.
